gpio_out_capture: RTL
=====================

Name: gpio_out_capture

Overview:
- Consumes the core's 8-bit GPIO output bus, downstream of the SoC top in the hardware test harness.
- Detects every change of the bus and timestamps it against a free-running cycle counter.
- Buffers each event in a small FIFO and presents the events to the harness checker over a valid/ready interface.
- Lets the bench check GPIO behaviour and timing without watching every cycle.

Parameters:
- WIDTH, 8, width of the observed GPIO bus.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- TS_WIDTH, 24, timestamp counter width in bits.

Ports:
- clk  input  1  single clock for all state.
- resetn  input  1  asynchronous active-low reset.
- gpio_pin_out  input  WIDTH  observed GPIO output bus, synchronous to clk.
- capture_en  input  1  1 = changes generate events.
- ev_valid  output  1  FIFO head holds an event.
- ev_ready  input  1  consumer accepts the head this cycle.
- ev_value  output  WIDTH  bus value after the change.
- ev_time  output  TS_WIDTH  timestamp of the change.
- ev_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one event was dropped.
- drop_count  output  8  saturating count of dropped events.
- clear_overflow  input  1  clears overflow and drop_count.

Behaviour:
- Clock and reset: one clock (clk). resetn is asynchronous and active-low.
- Reset values:
  - Timestamp counter = 0; prev_value = 0.
  - FIFO empty: ev_valid=0, ev_count=0.
  - ev_value=0, ev_time=0.
  - overflow=0, drop_count=0.
- Reset mid-operation: asserting resetn low discards all queued events immediately, with no handshake.
- Timestamp:
  - Counter increments by 1 every cycle resetn is high, regardless of capture_en.
  - Wraps from 2^TS_WIDTH-1 to 0 silently.
- Change detection:
  - Each cycle, change = (gpio_pin_out != prev_value).
  - prev_value <= gpio_pin_out every cycle, including when capture_en=0, so re-enabling never produces a stale event.
  - The first nonzero value after reset is an event, because prev_value resets to 0.
- Event generation:
  - Condition: change && capture_en in cycle N.
  - Event contents: {ev_time = counter value in cycle N, ev_value = gpio_pin_out in cycle N}.
  - Push occurs at the end of cycle N.
- Latency: with the FIFO empty, ev_valid rises in cycle N+1 with that event at the head.
- Handshake:
  - Pop when ev_valid && ev_ready.
  - ev_value and ev_time are stable while ev_valid=1 and ev_ready=0.
  - ev_ready while ev_valid=0 has no effect.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy counter, 0..DEPTH.
  - In-order, no reordering or coalescing.
- Simultaneous push and pop:
  - Always allowed; occupancy unchanged.
  - When full, a same-cycle pop frees a slot, so the push is accepted and no drop occurs.
  - When empty, the pop is impossible because ev_valid=0; the push proceeds normally.
- Full FIFO, push with no pop:
  - Event discarded.
  - overflow <= 1.
  - drop_count increments, saturating at 255.
  - FIFO contents unchanged.
- clear_overflow:
  - Clears overflow and drop_count to 0 next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- capture_en=0: no pushes; pops continue normally.
- X/unknown on gpio_pin_out is not modelled; the harness guarantees known values after reset.

Test Plan:
1. Reset, then drive gpio_pin_out 0x00 constant for 20 cycles, ev_ready=1 -> ev_valid stays 0, ev_count=0, overflow=0.
2. Reset, ev_ready=0, drive 0x01 at cycle 5, 0x03 at cycle 9, 0x02 at cycle 10 -> ev_count=3.
   - Then ev_ready=1 -> events drain in order: (0x01,t=5), (0x03,t=9), (0x02,t=10).
   - ev_valid first rises at cycle 6.
3. DEPTH=8, ev_ready=0, toggle the bus every cycle for 12 cycles -> ev_count=8, overflow=1, drop_count=4.
   - Drained events are the first 8 changes, with timestamps intact.
4. FIFO full, ev_ready=1 and a bus change in the same cycle -> ev_count stays 8, no drop, overflow unchanged.
   - The new event is last in drain order.
5. capture_en=0 while the bus changes 0x00->0x55, then capture_en=1 with the bus held at 0x55 -> no event.
   - A later change to 0xAA gives exactly one event (0xAA).
   - clear_overflow pulse after scenario 3 -> overflow=0, drop_count=0 next cycle.
6. TS_WIDTH=4: change at counter 15, then at counter 16 (wrapped) -> ev_time 15 then 0.
   - Assert resetn low while 3 events are queued -> ev_valid=0 and ev_count=0 immediately.

Source files
------------

// File: rtl/gpio_out_capture.sv
// Watches the GPIO output bus, timestamps every change against a free-running
// counter, and queues the events in a small FIFO read out over valid/ready.
module gpio_out_capture #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [WIDTH-1:0]           gpio_pin_out,
  input  logic                       capture_en,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [WIDTH-1:0]           ev_value,
  output logic [TS_WIDTH-1:0]        ev_time,
  output logic [$clog2(DEPTH):0]     ev_count,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clear_overflow
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = TS_WIDTH + WIDTH;

  logic [TS_WIDTH-1:0] ts_q,        ts_d;
  logic [WIDTH-1:0]    prev_q,      prev_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic                overflow_q,  overflow_d;
  logic [7:0]          drops_q,     drops_d;

  // Event storage carries no reset; occupancy alone decides what is valid.
  logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
  logic [ENTRY_W-1:0]  head_entry;

  logic change, push_req, pop, full, push_ok, drop;

  always_comb begin
    change   = (gpio_pin_out != prev_q);
    push_req = change && capture_en;
    pop      = (count_q != '0) && ev_ready;
    full     = (count_q == CNT_W'(DEPTH));
    // A same-cycle pop frees the slot the push needs, so a full FIFO only
    // drops when nothing leaves.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    ts_d     = ts_q + TS_WIDTH'(1);
    prev_d   = gpio_pin_out;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    overflow_d = overflow_q;
    drops_d    = drops_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drops_d    = 8'd0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drops_d != 8'hFF) begin
        drops_d = drops_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_q       <= '0;
      prev_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drops_q    <= 8'd0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drops_q    <= drops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= {ts_q, gpio_pin_out};
    end
  end

  always_comb begin
    head_entry = fifo_mem[rd_ptr_q];
    ev_valid   = (count_q != '0);
    ev_value   = ev_valid ? head_entry[WIDTH-1:0] : '0;
    ev_time    = ev_valid ? head_entry[ENTRY_W-1:WIDTH] : '0;
    ev_count   = count_q;
    overflow   = overflow_q;
    drop_count = drops_q;
  end

endmodule
